// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch sequencer.
package fetch_pkg;

  // Sequencer states: reset hold, imem settle wait, instruction presented, stopped.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  // Every LEGv8 instruction is one 32-bit word.
  localparam int INST_BYTES = 4;

  // `B .` -- branch to self, used by programs as a stop marker.
  localparam logic [31:0] HALT_INST_DEFAULT = 32'h1400_0000;

  // Width of the settle counter: it must hold RD_LATENCY-1, and never be zero bits wide.
  function automatic int cnt_width(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable down-counter that times the instruction-memory settle window.
module fetch_wait_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: reload wins, otherwise step down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, waits for the combinational
// instruction memory to settle, and hands instructions to decode over valid/ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] HALT_INST  = HALT_INST_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] startPC,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam int            CW     = cnt_width(RD_LATENCY);
  localparam logic [CW-1:0] RELOAD = CW'(RD_LATENCY - 1);

  fetch_state_e state_q, state_d;

  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic        xfer;
  logic        redirect_take;
  logic        is_halt_inst;
  logic        capture;
  logic        timer_load;
  logic        timer_done;

  // Redirects are ignored while still coming out of reset.
  assign redirect_take = redirect_valid && (state_q != IDLE);
  assign is_halt_inst  = (inst_q == HALT_INST);

  fetch_wait_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clk_i       (CLK),
    .rst_ni      (Reset_L),
    .load_i      (timer_load),
    .load_value_i(RELOAD),
    .done_o      (timer_done)
  );

  // State register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect always restarts the settle wait, ahead of any other move.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        if (redirect_take)   state_d = WAIT;
        else if (timer_done) state_d = VALID;
      end
      VALID: begin
        if (redirect_take) state_d = WAIT;
        else if (xfer)     state_d = is_halt_inst ? HALT : WAIT;
      end
      HALT: begin
        if (redirect_take) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State decode: handshake flags and control strobes for the datapath and timer.
  always_comb begin
    inst_valid = (state_q == VALID);
    halted     = (state_q == HALT);
    xfer       = inst_valid && inst_ready;
    capture    = (state_q == WAIT) && timer_done && !redirect_take;
    timer_load = (state_q == IDLE) || redirect_take ||
                 (xfer && !is_halt_inst);
  end

  // Datapath next values: PC steering, instruction capture, sticky misalign, transfer count.
  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    if (state_q == IDLE) begin
      pc_d = startPC;
    end else if (redirect_take) begin
      // Low bits are dropped so fetch stays word aligned; the fault is remembered.
      pc_d = {redirect_pc[63:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (xfer && !is_halt_inst) begin
      pc_d = pc_q + 64'(INST_BYTES);
    end

    if (capture) begin
      inst_d    = imem_data;
      inst_pc_d = pc_q;
    end

    // A transfer that coincides with a redirect still counts; decode squashes it.
    if (xfer) begin
      count_d = count_q + 32'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc_q       <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign misalign    = misalign_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam int          LAT  = 2;
  localparam logic [31:0] HALT = 32'h1400_0000;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [63:0] startPC = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:255];
  assign imem_data = mem[imem_addr[9:2]];

  always #5 CLK = ~CLK;

  fetch_sequencer #(.RD_LATENCY(LAT), .HALT_INST(HALT)) dut (
    .CLK           (CLK),
    .Reset_L       (Reset_L),
    .startPC       (startPC),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .halted        (halted),
    .misalign      (misalign),
    .fetch_count   (fetch_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    int          n;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [63:0] rpc,
                              input int n, input logic ev, input logic [31:0] ei,
                              input logic [63:0] ep, input logic [63:0] ea,
                              input logic [31:0] ec, input logic em);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.n = n; v.e_valid = ev; v.e_inst = ei;
    v.e_pc = ep; v.e_addr = ea; v.e_cnt = ec; v.e_mis = em;
    return v;
  endfunction

  task automatic do_reset(input logic [63:0] spc);
    Reset_L = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    startPC = spc;
    Reset_L = 1'b1;
  endtask

  // Reference model: tracks the PC, how many cycles since it was loaded,
  // and whether fetch has stopped; the instruction is whatever memory holds at PC.
  logic        m_idle, m_halt, m_mis;
  logic [63:0] m_pc;
  int          m_age;
  logic [31:0] m_cnt;

  function automatic logic m_valid();
    return !m_idle && !m_halt && (m_age >= LAT);
  endfunction

  task automatic model_edge(input logic rdy, input logic rv, input logic [63:0] rpc);
    logic v;
    v = m_valid();
    if (m_idle) begin
      m_pc = startPC; m_age = 0; m_idle = 1'b0;
    end else begin
      if (v && rdy) m_cnt = m_cnt + 32'd1;
      if (rv) begin
        m_pc = {rpc[63:2], 2'b00}; m_age = 0; m_halt = 1'b0;
        if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else if (v && rdy) begin
        if (mem[m_pc[9:2]] == HALT) m_halt = 1'b1;
        else begin m_pc = m_pc + 64'd4; m_age = 0; end
      end else if (!m_halt && m_age < LAT) begin
        m_age++;
      end
    end
  endtask

  initial begin
    logic ok;
    logic [31:0] w;

    for (int i = 0; i < 256; i++) mem[i] = 32'h8B00_0000 | 32'(i);
    mem[8'h00] = 32'hF840_03E9;
    mem[8'h01] = 32'hF840_83EA;
    mem[8'h07] = 32'hB400_00AC;
    mem[8'h0D] = 32'hD29B_DE09;
    mem[8'h13] = HALT;

    // Reset state while Reset_L is held low.
    #1;
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_mis", 64'(misalign), 64'd0);

    // Straight-line fetch, backpressure and redirect-with-transfer, row by row.
    tbl[0] = mk(1, 0, 0,     1, 0, 0,            0,     0,     0,  0);
    tbl[1] = mk(1, 0, 0,     2, 1, 32'hF84003E9, 0,     0,     0,  0);
    tbl[2] = mk(1, 0, 0,     1, 0, 0,            0,     4,     1,  0);
    tbl[3] = mk(0, 0, 0,     2, 1, 32'hF84083EA, 4,     4,     1,  0);
    tbl[4] = mk(0, 0, 0,     5, 1, 32'hF84083EA, 4,     4,     1,  0);
    tbl[5] = mk(1, 0, 0,     1, 0, 0,            0,     8,     2,  0);
    tbl[6] = mk(1, 0, 0,     2, 1, mem[2],       8,     8,     2,  0);
    tbl[7] = mk(1, 0, 0,    24, 1, mem[10],      'h28,  'h28,  10, 0);
    tbl[8] = mk(1, 1, 'h1C,  1, 0, 0,            0,     'h1C,  11, 0);
    tbl[9] = mk(0, 0, 0,     2, 1, 32'hB40000AC, 'h1C,  'h1C,  11, 0);

    do_reset(64'd0);
    for (int i = 0; i < 10; i++) begin
      inst_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      repeat (tbl[i].n) @(posedge CLK);
      @(negedge CLK);
      check($sformatf("row%0d_valid", i), 64'(inst_valid), 64'(tbl[i].e_valid));
      check($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("row%0d_count", i), 64'(fetch_count), 64'(tbl[i].e_cnt));
      check($sformatf("row%0d_mis", i), 64'(misalign), 64'(tbl[i].e_mis));
      check($sformatf("row%0d_halted", i), 64'(halted), 64'd0);
      if (tbl[i].e_valid) begin
        check($sformatf("row%0d_inst", i), 64'(inst), 64'(tbl[i].e_inst));
        check($sformatf("row%0d_pc", i), inst_pc, tbl[i].e_pc);
      end
      $display("row %0d: valid=%0d inst=%h pc=%h addr=%h count=%0d", i, inst_valid, inst,
               inst_pc, imem_addr, fetch_count);
    end
    redirect_valid = 1'b0;

    // Halt: the self-loop is accepted, then fetch stops until a redirect.
    do_reset(64'h4C);
    inst_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("halt_inst", 64'(inst), 64'(HALT));
    check("halt_inst_valid", 64'(inst_valid), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_count", 64'(fetch_count), 64'd1);
    check("halt_addr", imem_addr, 64'h4C);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (inst_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 64'h4C) ok = 1'b0;
    end
    check("halt_hold20", 64'(ok), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h34;
    @(posedge CLK);
    @(negedge CLK);
    redirect_valid = 1'b0;
    check("halt_exit_halted", 64'(halted), 64'd0);
    check("halt_exit_addr", imem_addr, 64'h34);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("halt_exit_inst", 64'(inst), 64'hD29BDE09);
    check("halt_exit_pc", inst_pc, 64'h34);
    $display("halt seq: inst=%h pc=%h count=%0d", inst, inst_pc, fetch_count);

    // Misaligned redirect is word-aligned and sets the sticky flag.
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h37;
    @(posedge CLK);
    @(negedge CLK);
    check("mis_addr", imem_addr, 64'h34);
    check("mis_flag", 64'(misalign), 64'd1);
    redirect_pc = 64'h1C;
    @(posedge CLK);
    @(negedge CLK);
    redirect_valid = 1'b0;
    check("mis_sticky", 64'(misalign), 64'd1);
    check("mis_addr2", imem_addr, 64'h1C);
    $display("misalign seq: addr=%h misalign=%0d", imem_addr, misalign);

    // Asynchronous reset in the middle of the settle wait.
    @(posedge CLK);
    #2 Reset_L = 1'b0;
    #1;
    check("arst_valid", 64'(inst_valid), 64'd0);
    check("arst_addr", imem_addr, 64'd0);
    check("arst_mis", 64'(misalign), 64'd0);
    check("arst_count", 64'(fetch_count), 64'd0);
    check("arst_inst", 64'(inst), 64'd0);
    check("arst_pc", inst_pc, 64'd0);
    @(negedge CLK);
    startPC = 64'h4;
    Reset_L = 1'b1;
    inst_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("arst_restart_inst", 64'(inst), 64'hF84083EA);
    check("arst_restart_pc", inst_pc, 64'h4);
    $display("reset seq: inst=%h pc=%h", inst, inst_pc);

    // Randomized run against the reference model.
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : w;
    end
    do_reset({54'd0, 8'($urandom_range(0, 255)), 2'b00});
    m_idle = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_pc = '0; m_age = 0; m_cnt = '0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = {54'd0, 10'($urandom_range(0, 1023))};
      model_edge(inst_ready, redirect_valid, redirect_pc);
      @(posedge CLK);
      @(negedge CLK);
      check("rnd_addr", imem_addr, m_pc);
      check("rnd_valid", 64'(inst_valid), 64'(m_valid()));
      check("rnd_halted", 64'(halted), 64'(m_halt));
      check("rnd_mis", 64'(misalign), 64'(m_mis));
      check("rnd_count", 64'(fetch_count), 64'(m_cnt));
      if (m_valid()) begin
        check("rnd_inst", 64'(inst), 64'(mem[m_pc[9:2]]));
        check("rnd_pc", inst_pc, m_pc);
      end
    end
    $display("random run: transfers=%0d misalign=%0d", fetch_count, misalign);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the LEGv8 datapath.
- Owns the program counter and drives the address into the instruction memory, which is a read-only, combinational-with-delay array.
- Waits a fixed number of cycles for read data to settle, then hands the 32-bit instruction and its PC to decode over a valid/ready handshake.
- Accepts branch redirects from execute and stops fetching on the self-loop `B .` (0x14000000).

Parameters:
- RD_LATENCY, 2: cycles imem_data must be stable after imem_addr changes; legal range 1..15.
- HALT_INST, 32'h14000000: encoding that triggers HALT once accepted.

Ports:
- CLK, input, 1: rising-edge clock.
- Reset_L, input, 1: asynchronous, active-low reset.
- startPC, input, 64: PC loaded on the first cycle after reset release.
- imem_addr, output, 64: address to the instruction memory; always equals the PC register.
- imem_data, input, 32: instruction memory read data.
- redirect_valid, input, 1: branch/jump taken; load redirect_pc.
- redirect_pc, input, 64: target address.
- inst_valid, output, 1: inst and inst_pc hold a fetched instruction.
- inst_ready, input, 1: decode accepts; transfer = inst_valid & inst_ready.
- inst, output, 32: captured instruction.
- inst_pc, output, 64: address inst was fetched from.
- halted, output, 1: sequencer is in HALT.
- misalign, output, 1: sticky; set when a redirect target has bits [1:0] != 0.
- fetch_count, output, 32: number of completed transfers; wraps modulo 2^32.

Behaviour:
- **Reset (Reset_L=0, asynchronous):**
  - state=IDLE, PC=0, wait counter=0.
  - inst=0, inst_pc=0, inst_valid=0, halted=0, misalign=0, fetch_count=0.
  - Reset mid-wait or mid-handshake discards everything.
- **IDLE:** first edge after release sets PC<=startPC, counter<=RD_LATENCY-1, goes to WAIT.
- **WAIT:**
  - If counter!=0, decrement.
  - If counter==0, set inst<=imem_data and inst_pc<=PC, raise inst_valid, go to VALID.
  - WAIT always lasts exactly RD_LATENCY cycles.
- **VALID:**
  - inst_valid=1; inst and inst_pc stay stable until transfer.
  - On transfer:
    - fetch_count+1 and inst_valid<=0.
    - If inst==HALT_INST, go to HALT with PC unchanged.
    - Else PC<=PC+4 (wraps modulo 2^64), counter reload, go to WAIT.
- **HALT:** halted=1, inst_valid=0, PC frozen. Only a redirect leaves HALT.
- **Redirect (any state except IDLE):**
  - Priority over every other transition.
  - PC<={redirect_pc[63:2],2'b00}, counter reload, inst_valid<=0, halted<=0, go to WAIT.
  - misalign<=1 if redirect_pc[1:0]!=0.
- **Redirect coincident with a transfer in VALID:**
  - The transfer counts (fetch_count increments).
  - PC takes redirect_pc, not PC+4. Decode squashes the younger instruction itself.
- **Throughput:** with inst_ready held at 1, one instruction every RD_LATENCY+1 cycles. There is no prefetch.
- **No combinational paths** from inputs to inst_valid, inst, or inst_pc. imem_addr is a direct register output.
- **Fixed-timing sampling:** imem_data X values are not checked; sampling occurs only at fixed timing.

Decomposition:
- Package fetch_pkg:
  - State enum: IDLE, WAIT, VALID, HALT (2-bit).
  - Constant INST_BYTES=4.
  - Default HALT_INST encoding.
  - Counter width function: clog2(RD_LATENCY).
- One sub-module, fetch_wait_timer: loadable down-counter with inputs load and load_value, and output done (counter==0). Instantiated once.
- FSM, PC, and output registers live in fetch_sequencer.

Test Plan:
1. **Straight-line fetch.** RD_LATENCY=2, startPC=0, inst_ready=1, test program memory attached, release reset.
   - inst_valid first high after the 3rd rising edge, with inst=F84003E9 and inst_pc=0.
   - Next transfer gives inst=F84083EA, inst_pc=4.
   - Transfers are spaced 3 cycles apart.
2. **Backpressure.** Hold inst_ready=0 for 5 cycles while inst_valid=1.
   - inst and inst_pc stay stable; imem_addr stays constant; fetch_count is unchanged.
   - Raise inst_ready: one transfer occurs and imem_addr steps by 4.
3. **Redirect.** While presenting inst_pc=0x28, pulse redirect_valid with redirect_pc=0x1C, coincident with the transfer.
   - fetch_count increments.
   - Next inst_pc=0x1C, inst=B40000AC.
   - misalign=0.
4. **Halt.** startPC=0x4C.
   - inst=14000000 is accepted, then halted=1 and inst_valid stays 0 for 20 cycles.
   - Redirect to 0x34 clears halted; next inst=D29BDE09.
5. **Misaligned redirect.** redirect_pc=0x37.
   - imem_addr=0x34 and misalign=1.
   - misalign stays 1 through a later aligned redirect.
6. **Reset mid-wait.** Assert Reset_L=0 during WAIT.
   - All outputs drop to reset values immediately, without waiting for a clock edge.
   - Fetch restarts from startPC after release.
